// File: rtl/pipe_stall_ctrl_if.sv
// Stall controller bundle: stage requests in, stall vector and
// multi-cycle status out.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic             ex_mc_start;
    logic [CNT_W-1:0] ex_mc_len;
    logic             flush;
    logic [5:0]       stall;
    logic             mc_busy;
    logic             mc_done;
    logic [CNT_W-1:0] mc_cnt;

    modport master (
        output stallreq_id,
        output stallreq_ex,
        output stallreq_mem,
        output ex_mc_start,
        output ex_mc_len,
        output flush,
        input  stall,
        input  mc_busy,
        input  mc_done,
        input  mc_cnt
    );

    modport slave (
        input  stallreq_id,
        input  stallreq_ex,
        input  stallreq_mem,
        input  ex_mc_start,
        input  ex_mc_len,
        input  flush,
        output stall,
        output mc_busy,
        output mc_done,
        output mc_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: merges stage stall requests and
// sequences multi-cycle EX operations with a countdown FSM.
module pipe_stall_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_stall_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ex_hold;
    logic             done;
    logic             cnt_zero;
    logic [CNT_W-1:0] len_m1;

    logic             sel_flush;
    logic             sel_mem;
    logic             sel_ex;
    logic             sel_id;
    logic [5:0]       stall_v;

    // A zero length behaves like a single-cycle op.
    assign cnt_zero = (cnt_q == '0);
    assign len_m1   = (bus.ex_mc_len == '0) ? '0
                    : bus.ex_mc_len - 1'b1;

    // State and countdown register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and EX hold/done decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_hold = 1'b0;
        done    = 1'b0;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ex_mc_start && !bus.stallreq_mem) begin
                        ex_hold = 1'b1;
                        cnt_d   = len_m1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!cnt_zero) begin
                        ex_hold = 1'b1;
                    end
                    if (!bus.stallreq_mem) begin
                        if (!cnt_zero) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // One-hot priority selects so the vector decode is exclusive.
    assign sel_flush = bus.flush;
    assign sel_mem   = !bus.flush && bus.stallreq_mem;
    assign sel_ex    = !bus.flush && !bus.stallreq_mem
                    && (bus.stallreq_ex || ex_hold);
    assign sel_id    = !bus.flush && !bus.stallreq_mem
                    && !bus.stallreq_ex && !ex_hold
                    && bus.stallreq_id;

    // Stall vector: flush > mem > ex/hold > id.
    always_comb begin
        stall_v = STALL_NONE;
        unique case (1'b1)
            sel_flush: stall_v = STALL_NONE;
            sel_mem:   stall_v = STALL_MEM;
            sel_ex:    stall_v = STALL_EX;
            sel_id:    stall_v = STALL_ID;
            default:   stall_v = STALL_NONE;
        endcase
    end

    assign bus.stall   = stall_v;
    assign bus.mc_busy = (state_q == RUN);
    assign bus.mc_done = done;
    assign bus.mc_cnt  = cnt_q;

endmodule
